// File: rtl/guia05_pkg.sv
// Shared encodings for the Guia 05 logic unit: op codes, FSM states, sweep length.
package guia05_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_ORN  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam int SWEEP_LEN = 32;

endpackage

// File: rtl/guia05_logic_core.sv
// Combinational bitwise evaluator for the eight two-operand logic functions.
module guia05_logic_core
    import guia05_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] s
);

    always_comb begin
        s = '0;
        case (op)
            OP_AND:  s = a & b;
            OP_OR:   s = a | b;
            OP_NAND: s = ~(a & b);
            OP_NOR:  s = ~(a | b);
            OP_XOR:  s = a ^ b;
            OP_XNOR: s = ~(a ^ b);
            OP_ANDN: s = a & ~b;
            OP_ORN:  s = ~a | b;
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/guia05_logic_unit.sv
// Registered logic unit with valid/ready handshake and a built-in 32-row truth-table sweep.
//
// state    | meaning
// ST_IDLE  | external operands accepted
// ST_SWEEP | sweep counter feeds the evaluator
// ST_DRAIN | last sweep row loaded, waiting for it to be accepted
module guia05_logic_unit
    import guia05_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_op,
    output logic             out_last
);

    state_e           state;
    logic [4:0]       cnt;
    logic             load_ok;
    logic             ext_load;
    logic             swp_load;
    logic             swp_last;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [2:0]       mux_op;
    logic [WIDTH-1:0] core_s;

    always_comb begin
        load_ok    = !out_valid || out_ready;
        in_ready   = (state == ST_IDLE) && !sweep_start && load_ok;
        ext_load   = in_valid && in_ready;
        swp_load   = (state == ST_SWEEP) && load_ok;
        swp_last   = (cnt == 5'(SWEEP_LEN - 1));
        sweep_busy = (state != ST_IDLE);
        sweep_done = (state == ST_DRAIN) && out_valid && out_ready && out_last;
        if (state == ST_SWEEP) begin
            mux_a  = {WIDTH{cnt[1]}};
            mux_b  = {WIDTH{cnt[0]}};
            mux_op = cnt[4:2];
        end else begin
            mux_a  = a;
            mux_b  = b;
            mux_op = op;
        end
    end

    guia05_logic_core #(.WIDTH(WIDTH)) u_core (
        .a  (mux_a),
        .b  (mux_b),
        .op (mux_op),
        .s  (core_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (ext_load || swp_load) begin
                out_valid <= 1'b1;
                s         <= core_s;
                out_a     <= mux_a;
                out_b     <= mux_b;
                out_op    <= mux_op;
                out_last  <= swp_load && swp_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (sweep_start) state <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (swp_load) begin
                        cnt <= cnt + 5'd1;
                        if (swp_last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (sweep_done) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_guia05_logic_unit.sv
// Scoreboard bench for guia05_logic_unit: truth-table reference model, randomized beats and sweeps.
module tb_guia05_logic_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         sweep_start = 1'b0;
    logic         sweep_busy;
    logic         sweep_done;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic [2:0]   out_op;
    logic         out_last;

    guia05_logic_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sweep_start(sweep_start), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   fails = 0;
    int   rows_acc = 0;
    int   done_cnt = 0;

    // Truth table per function, indexed by {a_bit, b_bit}.
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                           4'b0110, 4'b1001, 4'b0100, 4'b1011};

    function automatic logic [W-1:0] ref_eval(logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y);
        logic [W-1:0] r;
        logic [3:0]   t;
        t = tt[f];
        for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
        return r;
    endfunction

    function automatic exp_t mk(logic [2:0] f, logic [W-1:0] x, logic [W-1:0] y, logic l);
        exp_t e;
        e.s = ref_eval(f, x, y);
        e.a = x;
        e.b = y;
        e.op = f;
        e.last = l;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the presented result against the queue head, then records new acceptances.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    chk("s", 32'(s), 32'(sb[0].s));
                    chk("out_a", 32'(out_a), 32'(sb[0].a));
                    chk("out_b", 32'(out_b), 32'(sb[0].b));
                    chk("out_op", 32'(out_op), 32'(sb[0].op));
                    chk("out_last", 32'(out_last), 32'(sb[0].last));
                    chk("sweep_done", 32'(sweep_done), 32'(out_ready && sb[0].last));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        rows_acc++;
                    end
                end
            end else begin
                chk("sweep_done_idle", 32'(sweep_done), 32'd0);
            end
            if (sweep_done) done_cnt++;
            if (in_valid && in_ready) sb.push_back(mk(op, a, b, 1'b0));
            if (sweep_start && !sweep_busy) begin
                for (int k = 0; k < 32; k++)
                    sb.push_back(mk(3'(k >> 2), ((k >> 1) & 1) != 0 ? '1 : '0,
                                    (k & 1) != 0 ? '1 : '0, k == 31));
            end
        end
    end

    task automatic wait_idle(int maxc);
        int n = 0;
        while ((sweep_busy || out_valid || sb.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", 32'(n < maxc), 32'd1);
    endtask

    initial begin
        int n_valid, n_done, first_i, last_i, done_i, busy_after, n, done_before;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(sweep_busy), 32'd0);
        chk("rst_done", 32'(sweep_done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ANDN directed beat
        in_valid = 1'b1; op = 3'b110; a = 4'b1100; b = 4'b1010; out_ready = 1'b1;
        step();
        chk("andn_valid", 32'(out_valid), 32'd1);
        chk("andn_s", 32'(s), 32'b0100);
        chk("andn_last", 32'(out_last), 32'd0);

        // ORN held under backpressure; next beat waits, then goes in on release
        op = 3'b111;
        step();
        out_ready = 1'b0; op = 3'b000; a = 4'b1111; b = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_s", 32'(s), 32'b1011);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        wait_idle(20);

        // Sweep wins over a simultaneous external beat; full throughput
        sweep_start = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; op = $urandom;
        @(negedge clk);
        chk("start_in_ready", 32'(in_ready), 32'd0);
        step();
        sweep_start = 1'b0; in_valid = 1'b0;
        n_valid = 0; n_done = 0; first_i = -1; last_i = -1; done_i = -1; busy_after = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n_valid++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
            if (sweep_done) begin
                n_done++;
                done_i = i;
            end
            if (done_i >= 0 && i == done_i + 1) busy_after = int'(sweep_busy);
        end
        chk("sweep_rows", 32'(n_valid), 32'd32);
        chk("sweep_first", 32'(first_i), 32'd1);
        chk("sweep_span", 32'(last_i - first_i), 32'd31);
        chk("sweep_done_cnt", 32'(n_done), 32'd1);
        chk("sweep_done_at", 32'(done_i), 32'd32);
        chk("busy_fall", 32'(busy_after), 32'd0);
        wait_idle(10);

        // Sweep under random backpressure, with an ignored re-start
        rows_acc = 0; done_before = done_cnt;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        n = 0;
        while ((sweep_busy || out_valid) && n < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            sweep_start = (n == 3);
            step();
            n++;
        end
        sweep_start = 1'b0; out_ready = 1'b1;
        chk("rand_sweep_timeout", 32'(n < 400), 32'd1);
        chk("rand_sweep_rows", 32'(rows_acc), 32'd32);
        chk("rand_sweep_done", 32'(done_cnt - done_before), 32'd1);
        wait_idle(10);

        // Random external beats with random backpressure
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle(10);

        // Reset in the middle of a sweep
        rows_acc = 0; done_before = done_cnt;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        n = 0;
        while (rows_acc < 10 && n < 50) begin
            step();
            n++;
        end
        chk("reach_row10", 32'(rows_acc), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_s", 32'(s), 32'd0);
        chk("arst_ab", 32'({out_a, out_b}), 32'd0);
        chk("arst_op", 32'(out_op), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(sweep_busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("no_done_on_abort", 32'(done_cnt), 32'(done_before));
        step();
        rows_acc = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        wait_idle(60);
        chk("restart_rows", 32'(rows_acc), 32'd32);
        chk("restart_done", 32'(done_cnt - done_before), 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
